// File: rtl/dpr_fill.sv
// dpr_fill: dual-port RAM with one write port and one registered read port.
// After reset, a hardware sequencer writes FILL to every word. Port accesses
// are ignored until that sweep completes. An optional second output register
// adds one cycle of read latency.
module dpr_fill #(
    parameter int              AW     = 14,
    parameter int              DW     = 8,
    parameter logic [DW-1:0]   FILL   = {DW{1'b0}},
    parameter int              BYPASS = 1,
    parameter int              OREG   = 0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ce1,
    input  logic          we1,
    input  logic [DW-1:0] d1,
    input  logic [AW-1:0] a1,
    input  logic          ce2,
    input  logic [AW-1:0] a2,
    output logic [DW-1:0] q2,
    output logic          qv2,
    output logic          busy
);

    localparam int DEPTH  = 1 << AW;
    localparam int NSTAGE = (OREG != 0) ? 2 : 1;

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        state_reg;
    logic [AW-1:0] cnt_reg;
    logic          busy_reg;

    // Shared write port: driven by the fill sweep or by port 1
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic          rdw_hit;

    logic [DW-1:0] mem [DEPTH];

    // Output pipeline: stage 0 is the RAM read register, later stages are
    // optional output registers.
    logic [DW-1:0] stage_data  [NSTAGE];
    logic          stage_valid [NSTAGE];

    // Fill sequencer: sweep every address once, then hand the RAM to the ports
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= S_FILL;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
        end else if (state_reg == S_FILL) begin
            cnt_reg <= cnt_reg + AW'(1);
            if (cnt_reg == {AW{1'b1}}) begin
                state_reg <= S_RUN;
                busy_reg  <= 1'b0;
            end
        end
    end

    // Write-port arbitration; no write ever happens on a reset edge
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = cnt_reg;
        wr_data = FILL;
        if (!reset) begin
            if (state_reg == S_FILL) begin
                wr_en = 1'b1;
            end else if (ce1 && !we1) begin
                wr_en   = 1'b1;
                wr_addr = a1;
                wr_data = d1;
            end
        end
    end

    // Reads are only accepted once the fill is finished; a same-address
    // write on the same edge is a read-during-write collision
    always_comb begin
        rd_en   = (state_reg == S_RUN) && ce2;
        rdw_hit = rd_en && wr_en && (a1 == a2);
    end

    // RAM array write
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    generate
        for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage
            if (gi == 0) begin : g_read
                // Registered read; holds data when no read is accepted
                always_ff @(posedge clock) begin
                    if (reset) begin
                        stage_data[gi]  <= '0;
                        stage_valid[gi] <= 1'b0;
                    end else begin
                        stage_valid[gi] <= rd_en;
                        if (rd_en) begin
                            if ((BYPASS != 0) && rdw_hit) begin
                                stage_data[gi] <= d1;
                            end else begin
                                stage_data[gi] <= mem[a2];
                            end
                        end
                    end
                end
            end else begin : g_oreg
                // Extra output register: loads only when upstream data is new
                always_ff @(posedge clock) begin
                    if (reset) begin
                        stage_data[gi]  <= '0;
                        stage_valid[gi] <= 1'b0;
                    end else begin
                        stage_valid[gi] <= stage_valid[gi-1];
                        if (stage_valid[gi-1]) begin
                            stage_data[gi] <= stage_data[gi-1];
                        end
                    end
                end
            end
        end
    endgenerate

    assign q2   = stage_data[NSTAGE-1];
    assign qv2  = stage_valid[NSTAGE-1];
    assign busy = busy_reg;

endmodule

// File: tb/tb_dpr_fill.sv
// Directed bench for dpr_fill. Three builds share one stimulus stream:
// BYPASS=1/OREG=0, BYPASS=0/OREG=0 and BYPASS=1/OREG=1, all AW=4, FILL=8'hA5.
module tb_dpr_fill;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam logic [7:0] FV = 8'hA5;

    logic          clock;
    logic          reset;
    logic          ce1;
    logic          we1;
    logic [DW-1:0] d1;
    logic [AW-1:0] a1;
    logic          ce2;
    logic [AW-1:0] a2;

    logic [DW-1:0] q2_b1, q2_b0, q2_o;
    logic          qv2_b1, qv2_b0, qv2_o;
    logic          busy_b1, busy_b0, busy_o;

    int n_checks;
    int n_fail;

    dpr_fill #(.AW(AW), .DW(DW), .FILL(FV), .BYPASS(1), .OREG(0)) dut_b1 (
        .clock(clock), .reset(reset), .ce1(ce1), .we1(we1), .d1(d1), .a1(a1),
        .ce2(ce2), .a2(a2), .q2(q2_b1), .qv2(qv2_b1), .busy(busy_b1)
    );

    dpr_fill #(.AW(AW), .DW(DW), .FILL(FV), .BYPASS(0), .OREG(0)) dut_b0 (
        .clock(clock), .reset(reset), .ce1(ce1), .we1(we1), .d1(d1), .a1(a1),
        .ce2(ce2), .a2(a2), .q2(q2_b0), .qv2(qv2_b0), .busy(busy_b0)
    );

    dpr_fill #(.AW(AW), .DW(DW), .FILL(FV), .BYPASS(1), .OREG(1)) dut_o (
        .clock(clock), .reset(reset), .ce1(ce1), .we1(we1), .d1(d1), .a1(a1),
        .ce2(ce2), .a2(a2), .q2(q2_o), .qv2(qv2_o), .busy(busy_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One rising edge, then settle 1 time unit past it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Counts cycles with busy high, starting in the cycle just after release
    task automatic count_busy(output int cycles);
        cycles = 0;
        while (busy_b1 === 1'b1 && cycles < 100) begin
            cycles++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (busy_b1 !== 1'b1 || busy_b0 !== 1'b1 || busy_o !== 1'b1) begin
            $display("FAIL reset_busy: got %b%b%b exp 111", busy_b1, busy_b0, busy_o);
            n_fail++;
        end
        n_checks++;
        if (q2_b1 !== 8'h00 || q2_b0 !== 8'h00 || q2_o !== 8'h00) begin
            $display("FAIL reset_q2: got %h %h %h exp 00", q2_b1, q2_b0, q2_o);
            n_fail++;
        end
        n_checks++;
        if (qv2_b1 !== 1'b0 || qv2_b0 !== 1'b0 || qv2_o !== 1'b0) begin
            $display("FAIL reset_qv2: got %b%b%b exp 000", qv2_b1, qv2_b0, qv2_o);
            n_fail++;
        end
        $display("reset: busy=%b q2=%h qv2=%b", busy_b1, q2_b1, qv2_b1);
    endtask

    task automatic test_fill_sweep();
        int cyc;
        reset = 1'b0;
        count_busy(cyc);
        n_checks++;
        if (cyc != 16) begin
            $display("FAIL fill_busy_len: got %0d cycles exp 16", cyc);
            n_fail++;
        end
        n_checks++;
        if (busy_b0 !== 1'b0 || busy_o !== 1'b0) begin
            $display("FAIL fill_busy_end: got %b%b exp 00", busy_b0, busy_o);
            n_fail++;
        end
        $display("fill: busy high for %0d cycles", cyc);
        for (int a = 0; a < 16; a++) begin
            ce2 = 1'b1;
            a2  = AW'(a);
            tick();
            n_checks++;
            if (q2_b1 !== FV || qv2_b1 !== 1'b1 || q2_b0 !== FV || qv2_b0 !== 1'b1) begin
                $display("FAIL fill_read addr %0d: got %h/%b %h/%b exp %h/1",
                         a, q2_b1, qv2_b1, q2_b0, qv2_b0, FV);
                n_fail++;
            end
            if (a > 0) begin
                n_checks++;
                if (q2_o !== FV || qv2_o !== 1'b1) begin
                    $display("FAIL fill_read_oreg addr %0d: got %h/%b exp %h/1", a - 1, q2_o, qv2_o, FV);
                    n_fail++;
                end
            end
            $display("fill read addr %0d: q2=%h qv2=%b", a, q2_b1, qv2_b1);
        end
        ce2 = 1'b0;
        tick();
        n_checks++;
        if (q2_o !== FV || qv2_o !== 1'b1 || qv2_b1 !== 1'b0 || q2_b1 !== FV) begin
            $display("FAIL fill_read_tail: got oreg %h/%b b1 %h/%b exp %h/1 %h/0",
                     q2_o, qv2_o, q2_b1, qv2_b1, FV, FV);
            n_fail++;
        end
    endtask

    task automatic test_write_read();
        ce1 = 1'b1; we1 = 1'b0; a1 = 4'd5; d1 = 8'h3C;
        tick();
        ce1 = 1'b0; we1 = 1'b1;
        ce2 = 1'b1; a2 = 4'd5;
        tick();
        n_checks++;
        if (q2_b1 !== 8'h3C || qv2_b1 !== 1'b1 || q2_b0 !== 8'h3C || qv2_b0 !== 1'b1) begin
            $display("FAIL wr_rd: got %h/%b %h/%b exp 3c/1", q2_b1, qv2_b1, q2_b0, qv2_b0);
            n_fail++;
        end
        n_checks++;
        if (qv2_o !== 1'b0) begin
            $display("FAIL wr_rd_oreg_early: got qv2=%b exp 0", qv2_o);
            n_fail++;
        end
        ce2 = 1'b0;
        tick();
        n_checks++;
        if (q2_b1 !== 8'h3C || qv2_b1 !== 1'b0) begin
            $display("FAIL wr_rd_hold: got %h/%b exp 3c/0", q2_b1, qv2_b1);
            n_fail++;
        end
        n_checks++;
        if (q2_o !== 8'h3C || qv2_o !== 1'b1) begin
            $display("FAIL wr_rd_oreg: got %h/%b exp 3c/1", q2_o, qv2_o);
            n_fail++;
        end
        $display("write/read addr 5: q2=%h qv2=%b", q2_b1, qv2_b1);
        tick();
    endtask

    task automatic test_rdw();
        ce1 = 1'b1; we1 = 1'b0; a1 = 4'd7; d1 = 8'h11;
        tick();
        d1 = 8'h22; ce2 = 1'b1; a2 = 4'd7;
        tick();
        n_checks++;
        if (q2_b1 !== 8'h22 || qv2_b1 !== 1'b1) begin
            $display("FAIL rdw_bypass1: got %h/%b exp 22/1", q2_b1, qv2_b1);
            n_fail++;
        end
        n_checks++;
        if (q2_b0 !== 8'h11 || qv2_b0 !== 1'b1) begin
            $display("FAIL rdw_bypass0: got %h/%b exp 11/1", q2_b0, qv2_b0);
            n_fail++;
        end
        $display("rdw addr 7: bypass1 q2=%h bypass0 q2=%h", q2_b1, q2_b0);
        ce1 = 1'b0; we1 = 1'b1;
        tick();
        n_checks++;
        if (q2_b1 !== 8'h22 || q2_b0 !== 8'h22) begin
            $display("FAIL rdw_after: got %h %h exp 22", q2_b1, q2_b0);
            n_fail++;
        end
        // ce1 with we1 high must not write
        ce2 = 1'b0; ce1 = 1'b1; we1 = 1'b1; d1 = 8'h99;
        tick();
        ce1 = 1'b0; ce2 = 1'b1;
        tick();
        n_checks++;
        if (q2_b1 !== 8'h22 || q2_b0 !== 8'h22) begin
            $display("FAIL we1_high_nowrite: got %h %h exp 22", q2_b1, q2_b0);
            n_fail++;
        end
        $display("read after we1=1 addr 7: q2=%h", q2_b1);
        ce2 = 1'b0;
        tick();
    endtask

    task automatic test_busy_access();
        int bad;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ce1 = 1'b1; we1 = 1'b0; a1 = 4'd3; d1 = 8'hFF;
        ce2 = 1'b1; a2 = 4'd3;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (qv2_b1 !== 1'b0 || q2_b1 !== 8'h00 || qv2_o !== 1'b0 || q2_o !== 8'h00 || busy_b1 !== 1'b1)
                bad++;
        end
        n_checks++;
        if (bad != 0) begin
            $display("FAIL busy_access_outputs: got %0d bad cycles exp 0", bad);
            n_fail++;
        end
        ce1 = 1'b0; we1 = 1'b1; ce2 = 1'b0;
        tick();
        n_checks++;
        if (busy_b1 !== 1'b0) begin
            $display("FAIL busy_access_end: got busy=%b exp 0", busy_b1);
            n_fail++;
        end
        ce2 = 1'b1; a2 = 4'd3;
        tick();
        n_checks++;
        if (q2_b1 !== FV || qv2_b1 !== 1'b1) begin
            $display("FAIL busy_access_addr3: got %h/%b exp %h/1", q2_b1, qv2_b1, FV);
            n_fail++;
        end
        $display("busy access: addr 3 after fill q2=%h", q2_b1);
        ce2 = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_fill();
        int cyc;
        // Plant non-fill data that only the second sweep can clear
        ce1 = 1'b1; we1 = 1'b0; a1 = 4'd12; d1 = 8'h5A;
        tick();
        a1 = 4'd2;
        tick();
        ce1 = 1'b0; we1 = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_busy(cyc);
        n_checks++;
        if (cyc != 16) begin
            $display("FAIL midfill_busy_len: got %0d cycles exp 16", cyc);
            n_fail++;
        end
        $display("mid-fill reset: busy high for %0d cycles", cyc);
        for (int a = 0; a < 16; a++) begin
            ce2 = 1'b1;
            a2  = AW'(a);
            tick();
            n_checks++;
            if (q2_b1 !== FV || qv2_b1 !== 1'b1) begin
                $display("FAIL midfill_read addr %0d: got %h/%b exp %h/1", a, q2_b1, qv2_b1, FV);
                n_fail++;
            end
        end
        ce2 = 1'b0;
        tick();
    endtask

    task automatic test_oreg_latency();
        ce1 = 1'b1; we1 = 1'b0;
        for (int a = 1; a <= 3; a++) begin
            a1 = AW'(a);
            d1 = DW'(a);
            tick();
        end
        ce1 = 1'b0; we1 = 1'b1;
        ce2 = 1'b1; a2 = 4'd1;
        tick();
        n_checks++;
        if (qv2_o !== 1'b0 || q2_b1 !== 8'h01) begin
            $display("FAIL oreg_edge_k: got oreg qv2=%b b1 q2=%h exp 0 01", qv2_o, q2_b1);
            n_fail++;
        end
        a2 = 4'd2;
        tick();
        n_checks++;
        if (q2_o !== 8'h01 || qv2_o !== 1'b1) begin
            $display("FAIL oreg_k1: got %h/%b exp 01/1", q2_o, qv2_o);
            n_fail++;
        end
        $display("oreg k+1: q2=%h qv2=%b", q2_o, qv2_o);
        a2 = 4'd3;
        tick();
        n_checks++;
        if (q2_o !== 8'h02 || qv2_o !== 1'b1) begin
            $display("FAIL oreg_k2: got %h/%b exp 02/1", q2_o, qv2_o);
            n_fail++;
        end
        $display("oreg k+2: q2=%h qv2=%b", q2_o, qv2_o);
        ce2 = 1'b0;
        tick();
        n_checks++;
        if (q2_o !== 8'h03 || qv2_o !== 1'b1) begin
            $display("FAIL oreg_k3: got %h/%b exp 03/1", q2_o, qv2_o);
            n_fail++;
        end
        $display("oreg k+3: q2=%h qv2=%b", q2_o, qv2_o);
        tick();
        n_checks++;
        if (q2_o !== 8'h03 || qv2_o !== 1'b0) begin
            $display("FAIL oreg_hold: got %h/%b exp 03/0", q2_o, qv2_o);
            n_fail++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        ce1 = 1'b0; we1 = 1'b1; d1 = '0; a1 = '0;
        ce2 = 1'b0; a2 = '0;
        test_reset();
        test_fill_sweep();
        test_write_read();
        test_rdw();
        test_busy_access();
        test_reset_mid_fill();
        test_oreg_latency();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dpr_fill.md
# dpr_fill

Parametrised dual-port RAM with one write port and one registered read port. Adds configurable data width, a selectable read-during-write mode, an optional second output register and a read-valid strobe. A hardware fill sequencer writes a constant value to every word after reset. It is used for video and shadow memories that must start from a known state without a CPU clear loop.

## Interface
- `AW`, 14: address width; depth is 2**AW words.
- `DW`, 8: data width.
- `FILL`, {DW{1'b0}}: value written to every word by the reset fill.
- `BYPASS`, 1: 1 = a same-cycle same-address read returns the new write data; 0 = it returns the old data.
- `OREG`, 0: 1 = adds a second output register, so read latency is 2.
- `clock` in 1: the single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `ce1` in 1: write-port enable.
- `we1` in 1: write strobe, active-low; a write occurs when ce1=1 and we1=0.
- `d1` in DW: write data.
- `a1` in AW: write address.
- `ce2` in 1: read-port enable.
- `a2` in AW: read address.
- `q2` out DW: read data.
- `qv2` out 1: one-cycle strobe marking new data on q2.
- `busy` out 1: high while the fill is pending or running.

## Operation
- The state machine has two states, FILL and RUN.
- **Reset behaviour**
  - Any edge with reset=1 sets state=FILL, fill counter=0, busy=1, q2=0, qv2=0, and clears the OREG stage (data 0, valid 0).
  - No RAM write occurs while reset=1.
- **FILL state** (reset=0)
  - Each edge writes FILL to ram[cnt], then cnt increments.
  - The edge that writes address 2**AW-1 moves the state to RUN and sets busy=0.
  - The counter is AW bits wide; the terminal compare is against all-ones, so wrap-around is never used.
- **Accesses during FILL**
  - Port-1 writes are ignored.
  - Port-2 reads are ignored: q2 holds and qv2=0.
- **Reset during FILL** restarts the sweep from address 0.
- **Reset during RUN** re-enters FILL; RAM contents are then overwritten by the sweep.
- **Writes in RUN**
  - A write happens when ce1=1 and we1=0: ram[a1] <= d1.
  - ce1=1 with we1=1 does nothing.
- **Reads in RUN, OREG=0**
  - ce2=1: q2 <= ram[a2] and qv2 <= 1.
  - ce2=0: q2 holds and qv2 <= 0.
- **Read-during-write**
  - Applies on the same edge when there is a write, ce2=1 and a1==a2.
  - BYPASS=1: q2 <= d1.
  - BYPASS=0: q2 <= the pre-write contents.
  - Different addresses are independent.
- **OREG=1**
  - Stage 1 behaves exactly as q2 does in the OREG=0 case.
  - Stage 2 loads the stage-1 data whenever stage-1 valid=1; otherwise it holds.
  - q2 and qv2 are driven from stage 2.
- **Reset values**: q2=0, qv2=0, busy=1.

## Timing
- **Fill duration**: reset deasserts before edge N. Writes occur at edges N .. N+2**AW-1. busy falls after edge N+2**AW-1, so it is low from cycle 2**AW after reset release.
- **Read latency**
  - Address presented before edge k gives data and qv2=1 after edge k (OREG=0) or after edge k+1 (OREG=1).
  - Back-to-back reads sustain one word per cycle.
- **Write-to-read visibility**: a write at edge k is readable by a different-port read presented at edge k+1. At edge k itself, visibility follows BYPASS.
- **qv2** is exactly one cycle per accepted read and is never high while busy=1. The exception is OREG=1, where a read accepted at the last RUN edge before a reset is discarded by the reset.

## Test plan
- **Fill sweep and read-back** (AW=4, FILL=8'hA5)
  - Stimulus: pulse reset for 1 cycle.
  - Required: busy=1 for exactly 16 cycles after release; then reading addresses 0..15 returns 8'hA5 for each, with qv2 one cycle after each read.
- **Write/read in RUN**
  - Stimulus: write 8'h3C to address 5, then read address 5 on the next cycle.
  - Required: q2=8'h3C with qv2=1 one cycle after the read; a ce2=0 cycle after that holds q2=8'h3C with qv2=0.
- **Read-during-write**
  - Stimulus: address 7 holds 8'h11; write 8'h22 and read address 7 on the same edge.
  - Required: q2=8'h22 with BYPASS=1 and q2=8'h11 with BYPASS=0. A following read returns 8'h22 in both builds.
- **Reset mid-fill**
  - Stimulus: assert reset at fill cycle 9 (AW=4) and release it.
  - Required: busy stays high for a further 16 full cycles; all words read back FILL.
- **Accesses during busy**
  - Stimulus: while busy=1, write 8'hFF to address 3 and issue reads.
  - Required: qv2 stays 0 and q2 holds 0. After fill, address 3 reads FILL.
- **OREG=1 latency**
  - Stimulus: read addresses 1, 2, 3 back-to-back, holding 8'h01, 8'h02, 8'h03.
  - Required: data appears on q2 at edges k+1, k+2, k+3 with qv2 high for those 3 consecutive cycles.
